fm_stats_stage: RTL and testbench
=================================

FM_STATS_STAGE -- requirements
Module: fm_stats_stage

Interface
REQ-001 Parameter BW, default 16: signed integer width of each input lane sample.
REQ-002 Parameter LANES, default 8: samples per input beat.
REQ-003 Parameter CH, default 4: independent statistics channels (accumulator banks).
REQ-004 Parameter LEN_W, default 12: beat-count width per frame; max frame length is 2^LEN_W-1 beats.
REQ-005 Derived: CW = LEN_W+$clog2(LANES) (sample count); SW = BW+CW (sum); QW = 2*BW+CW (sum of squares); CHW = max(1,$clog2(CH)).
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rstn  in  1  reset, asynchronous, active-low.
REQ-008 mode  in  1  0 = mean and variance; 1 = mean forced 0, second moment E[x^2]; sampled on last-beat acceptance.
REQ-009 s_data  in  LANES*BW  lane samples, lane 0 in the LSBs.
REQ-010 s_chan  in  CHW  channel of the current beat.
REQ-011 s_valid / s_last / s_ready  in / in / out  1 each  input handshake; s_last marks the final beat of the frame on s_chan.
REQ-012 max_index / min_index  out  LANES  one-hot lane of the max/min sample of the last accepted beat.
REQ-013 index_valid / index_last  out  1 each  qualify max_index/min_index; index_last copies s_last.
REQ-014 m_mean  out  BW  signed frame mean.
REQ-015 m_var  out  2*BW  unsigned variance (mode 0) or second moment (mode 1).
REQ-016 m_count  out  CW  samples in the frame; m_chan  out  CHW  channel of the result; m_ovf  out  1  frame-length overflow flag.
REQ-017 m_valid / m_ready  out / in  1 each  result handshake.

Function
REQ-018 A beat is accepted when s_valid && s_ready; it adds the sum of its LANES samples and the sum of their squares to bank s_chan and adds 1 to that bank's beat count.
REQ-019 Beats of different channels may interleave freely; each bank accumulates independently.
REQ-020 index outputs are registered: one cycle after acceptance, index_valid=1 for one cycle; on ties the lowest lane index wins; index_valid=0 otherwise.
REQ-021 The FSM states are IDLE, DIV, SQ, OUT; reset state IDLE.
REQ-022 IDLE: s_ready=1; acceptance with s_last snapshots the completed bank (sum, sumsq, count including this beat, channel, mode), clears that bank in the same edge, and moves to DIV.
REQ-023 DIV: s_ready=0; restoring division, one quotient bit per cycle, computes |sum|/count and sumsq/count in parallel over exactly QW cycles, then SQ.
REQ-024 Mean = |sum|/count with sign restored (truncation toward zero), width BW.
REQ-025 SQ (1 cycle): mode 0 gives m_var = floor(sumsq/count) - mean^2, clamped to 0 if negative; mode 1 gives m_var = floor(sumsq/count) and m_mean = 0; then OUT.
REQ-026 OUT: m_valid=1, all m_* held stable until m_ready=1; on that edge m_valid drops and the FSM enters IDLE; s_ready=0 throughout OUT.
REQ-027 Latency: last beat accepted at edge T gives m_valid=1 after edge T+QW+1, i.e. QW+2 cycles; a simultaneous m_ready adds no bubble beyond returning to IDLE.
REQ-028 Overflow: a beat accepted when the bank count is 2^LEN_W-1 does not change the count or accumulators and sets a sticky per-bank flag; that flag appears on m_ovf for the frame and clears with the bank.
REQ-029 A frame of one beat is legal: m_count=LANES.
REQ-030 s_last on a bank with no prior beats is handled as a one-beat frame.

Reset
REQ-031 While rstn=0: all banks, counters and flags = 0; FSM = IDLE; s_ready=0; m_valid, index_valid, index_last, m_ovf = 0; all data outputs = 0.
REQ-032 s_ready rises on the first clock after rstn deasserts; reset during DIV, SQ or OUT aborts the result with no m_valid pulse.

Verification
REQ-033 LANES=8, chan 0, one beat of all lanes = 3, s_last -> m_mean=3, m_var=0, m_count=8, m_chan=0, m_valid at cycle QW+2.
REQ-034 One beat with lanes 0..7 -> m_mean=3 (28/8 truncated), m_var=140/8-9=8; max_index=0x80, min_index=0x01, index_valid one cycle after acceptance.
REQ-035 All lanes = -5, mode 0 -> m_mean=-5, m_var=0; same with mode 1 -> m_mean=0, m_var=25; all-equal beat -> max_index=min_index=0x01.
REQ-036 Interleave chan 1 and chan 2 beats, close chan 2 first, hold m_ready=0 for 10 cycles -> m_valid and data stable, s_ready=0; after acceptance chan 1 continues and its result is correct.
REQ-037 Assert rstn=0 mid-DIV -> all outputs 0 immediately; the next frame gives correct results with no stale accumulation.
REQ-038 LEN_W=2: send 5 beats on one channel -> m_count=12, m_ovf=1; the next frame on that channel has m_ovf=0.

Source files
------------

// File: rtl/fm_stats_stage.sv
// fm_stats_stage: per-channel accumulation of lane samples and their squares.
// A closed frame is handed to a serial restoring divider that yields the mean
// and variance (or second moment), which are then held until m_ready.

// Per-lane helper: sign-extended sample and its square
module fm_stats_lane #(
   parameter int BW = 16,
   parameter int SW = 31,
   parameter int QW = 47
) (
   input  logic [BW-1:0] x,
   output logic [SW-1:0] ext,
   output logic [QW-1:0] sq
);
   logic signed [2*BW-1:0] prod;

   assign prod = $signed(x) * $signed(x);
   assign ext  = SW'($signed(x));
   // a square is never negative, so zero-extension is exact
   assign sq   = QW'($unsigned(prod));
endmodule

module fm_stats_stage #(
   parameter  int BW    = 16,
   parameter  int LANES = 8,
   parameter  int CH    = 4,
   parameter  int LEN_W = 12,
   localparam int CW    = LEN_W + $clog2(LANES),
   localparam int SW    = BW + CW,
   localparam int QW    = 2*BW + CW,
   localparam int CHW   = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                mode,
   input  logic [LANES*BW-1:0] s_data,
   input  logic [CHW-1:0]      s_chan,
   input  logic                s_valid,
   input  logic                s_last,
   output logic                s_ready,
   output logic [LANES-1:0]    max_index,
   output logic [LANES-1:0]    min_index,
   output logic                index_valid,
   output logic                index_last,
   output logic [BW-1:0]       m_mean,
   output logic [2*BW-1:0]     m_var,
   output logic [CW-1:0]       m_count,
   output logic [CHW-1:0]      m_chan,
   output logic                m_ovf,
   output logic                m_valid,
   input  logic                m_ready
);
   localparam int VW  = 2*BW;
   localparam int SCW = $clog2(QW+1);
   localparam logic [LEN_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, DIV, SQ, OUT} state_t;
   state_t state, state_nx;

   logic [LANES-1:0][BW-1:0] lane;
   logic [LANES-1:0][SW-1:0] lane_ext;
   logic [LANES-1:0][QW-1:0] lane_sq;

   logic [CH-1:0][SW-1:0]    bank_sum;
   logic [CH-1:0][QW-1:0]    bank_sq;
   logic [CH-1:0][LEN_W-1:0] bank_cnt;
   logic [CH-1:0]            bank_ovf;

   logic [SW-1:0]    beat_sum, nx_sum;
   logic [QW-1:0]    beat_sq, nx_sq;
   logic [LEN_W-1:0] nx_cnt;
   logic             nx_ovf, ovf_hit;
   logic [BW-1:0]    max_val, min_val;
   logic [LANES-1:0] max_oh, min_oh;
   logic             accept, close, rdy_en, idx_vld;

   // divider state: quo_* shifts the dividend out and the quotient in
   logic [QW-1:0]  quo_a, quo_b;
   logic [CW-1:0]  rem_a, rem_b, dvsr;
   logic [CW:0]    ta, tb, da, db;
   logic           ge_a, ge_b;
   logic [SCW-1:0] step;
   logic           neg, fr_mode, fr_ovf;
   logic [CHW-1:0] fr_chan;

   logic [BW-1:0] mag, mean_s;
   logic [VW-1:0] ex2, msq, var0;
   logic          unused;

   assign lane    = s_data;
   assign s_ready = rdy_en && (state == IDLE);
   assign m_valid = (state == OUT);
   assign accept  = s_valid && s_ready;
   assign close   = accept && s_last;
   assign index_valid = idx_vld;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      fm_stats_lane #(.BW(BW), .SW(SW), .QW(QW)) u_lane (
         .x   (lane[i]),
         .ext (lane_ext[i]),
         .sq  (lane_sq[i])
      );
   end

   // beat totals plus arg-max/arg-min; strict compares keep the lowest lane on ties
   always_comb begin
      beat_sum = '0;
      beat_sq  = '0;
      max_val  = lane[0];
      min_val  = lane[0];
      max_oh   = LANES'(1);
      min_oh   = LANES'(1);
      for (int i = 0; i < LANES; i++) begin
         beat_sum = beat_sum + lane_ext[i];
         beat_sq  = beat_sq + lane_sq[i];
         if ($signed(lane[i]) > $signed(max_val)) begin
            max_val   = lane[i];
            max_oh    = '0;
            max_oh[i] = 1'b1;
         end
         if ($signed(lane[i]) < $signed(min_val)) begin
            min_val   = lane[i];
            min_oh    = '0;
            min_oh[i] = 1'b1;
         end
      end
   end

   // bank contents after this beat; a full bank only records the overflow
   always_comb begin
      ovf_hit = (bank_cnt[s_chan] == CNT_MAX);
      nx_sum  = bank_sum[s_chan];
      nx_sq   = bank_sq[s_chan];
      nx_cnt  = bank_cnt[s_chan];
      nx_ovf  = bank_ovf[s_chan] | ovf_hit;
      if (!ovf_hit) begin
         nx_sum = nx_sum + beat_sum;
         nx_sq  = nx_sq + beat_sq;
         nx_cnt = nx_cnt + 1'b1;
      end
   end

   // accumulator banks: update on each beat, clear when the frame closes
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bank_sum <= '0;
         bank_sq  <= '0;
         bank_cnt <= '0;
         bank_ovf <= '0;
      end else if (accept) begin
         if (s_last) begin
            bank_sum[s_chan] <= '0;
            bank_sq[s_chan]  <= '0;
            bank_cnt[s_chan] <= '0;
            bank_ovf[s_chan] <= 1'b0;
         end else begin
            bank_sum[s_chan] <= nx_sum;
            bank_sq[s_chan]  <= nx_sq;
            bank_cnt[s_chan] <= nx_cnt;
            bank_ovf[s_chan] <= nx_ovf;
         end
      end
   end

   // registered lane index report, one cycle after acceptance
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idx_vld    <= 1'b0;
         index_last <= 1'b0;
         max_index  <= '0;
         min_index  <= '0;
      end else begin
         idx_vld    <= accept;
         index_last <= accept & s_last;
         if (accept) begin
            max_index <= max_oh;
            min_index <= min_oh;
         end
      end
   end

   // input ready is held off until the first clock after reset release
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) rdy_en <= 1'b0;
      else       rdy_en <= 1'b1;
   end

   // state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (close) state_nx = DIV;
         DIV:     if (step == SCW'(QW-1)) state_nx = SQ;
         SQ:      state_nx = OUT;
         OUT:     if (m_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // one restoring-division step for both dividends against the sample count
   always_comb begin
      ta   = {rem_a, quo_a[QW-1]};
      tb   = {rem_b, quo_b[QW-1]};
      da   = ta - {1'b0, dvsr};
      db   = tb - {1'b0, dvsr};
      ge_a = (ta >= {1'b0, dvsr});
      ge_b = (tb >= {1'b0, dvsr});
   end

   // final arithmetic: signed mean and E[x^2] - mean^2 clamped at zero
   always_comb begin
      mag    = quo_a[BW-1:0];
      mean_s = neg ? -mag : mag;
      ex2    = quo_b[VW-1:0];
      msq    = VW'(mag) * VW'(mag);
      var0   = (ex2 >= msq) ? ex2 - msq : '0;
   end

   assign unused = ^{quo_a[QW-1:BW], quo_b[QW-1:VW], da[CW], db[CW]};

   // frame snapshot, divider iteration and result registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         quo_a   <= '0;
         quo_b   <= '0;
         rem_a   <= '0;
         rem_b   <= '0;
         dvsr    <= '0;
         step    <= '0;
         neg     <= 1'b0;
         fr_mode <= 1'b0;
         fr_ovf  <= 1'b0;
         fr_chan <= '0;
         m_mean  <= '0;
         m_var   <= '0;
         m_count <= '0;
         m_chan  <= '0;
         m_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (close) begin
               neg     <= nx_sum[SW-1];
               quo_a   <= QW'(nx_sum[SW-1] ? -nx_sum : nx_sum);
               quo_b   <= nx_sq;
               rem_a   <= '0;
               rem_b   <= '0;
               dvsr    <= CW'(nx_cnt) * CW'(LANES);
               step    <= '0;
               fr_mode <= mode;
               fr_chan <= s_chan;
               fr_ovf  <= nx_ovf;
            end
            DIV: begin
               rem_a <= ge_a ? da[CW-1:0] : ta[CW-1:0];
               rem_b <= ge_b ? db[CW-1:0] : tb[CW-1:0];
               quo_a <= {quo_a[QW-2:0], ge_a};
               quo_b <= {quo_b[QW-2:0], ge_b};
               step  <= step + 1'b1;
            end
            SQ: begin
               m_mean  <= fr_mode ? '0 : mean_s;
               m_var   <= fr_mode ? ex2 : var0;
               m_count <= dvsr;
               m_chan  <= fr_chan;
               m_ovf   <= fr_ovf;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fm_stats_stage.sv
// Bench for fm_stats_stage: single-beat frame vector table with a result
// scoreboard, plus sequences for interleave/backpressure, reset mid-division
// and frame-length overflow on a short-length instance.
module tb_fm_stats_stage;
   localparam int QW = 47;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   // main instance (defaults)
   logic         mode = 1'b0;
   logic [127:0] s_data = '0;
   logic [1:0]   s_chan = '0;
   logic         s_valid = 1'b0, s_last = 1'b0, s_ready;
   logic [7:0]   max_index, min_index;
   logic         index_valid, index_last;
   logic [15:0]  m_mean;
   logic [31:0]  m_var;
   logic [14:0]  m_count;
   logic [1:0]   m_chan;
   logic         m_ovf, m_valid;
   logic         m_ready = 1'b1;

   // short-frame instance: LEN_W=2, LANES=4
   logic        mode2 = 1'b0;
   logic [63:0] s_data2 = '0;
   logic [1:0]  s_chan2 = '0;
   logic        s_valid2 = 1'b0, s_last2 = 1'b0, s_ready2;
   logic [3:0]  max_index2, min_index2;
   logic        index_valid2, index_last2;
   logic [15:0] m_mean2;
   logic [31:0] m_var2;
   logic [3:0]  m_count2;
   logic [1:0]  m_chan2;
   logic        m_ovf2, m_valid2;
   logic        m_ready2 = 1'b1;

   fm_stats_stage dut (
      .clk(clk), .rstn(rstn), .mode(mode), .s_data(s_data), .s_chan(s_chan),
      .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .max_index(max_index), .min_index(min_index),
      .index_valid(index_valid), .index_last(index_last),
      .m_mean(m_mean), .m_var(m_var), .m_count(m_count), .m_chan(m_chan),
      .m_ovf(m_ovf), .m_valid(m_valid), .m_ready(m_ready)
   );

   fm_stats_stage #(.LEN_W(2), .LANES(4)) dut2 (
      .clk(clk), .rstn(rstn), .mode(mode2), .s_data(s_data2), .s_chan(s_chan2),
      .s_valid(s_valid2), .s_last(s_last2), .s_ready(s_ready2),
      .max_index(max_index2), .min_index(min_index2),
      .index_valid(index_valid2), .index_last(index_last2),
      .m_mean(m_mean2), .m_var(m_var2), .m_count(m_count2), .m_chan(m_chan2),
      .m_ovf(m_ovf2), .m_valid(m_valid2), .m_ready(m_ready2)
   );

   typedef struct packed {
      logic signed [15:0] mean;
      logic [31:0]        vr;
      logic [14:0]        count;
      logic [1:0]         chan;
      logic               ovf;
   } res_t;

   typedef struct packed {
      logic               md;
      logic [1:0]         ch;
      logic [127:0]       d;
      logic signed [15:0] mean;
      logic [31:0]        vr;
      logic [7:0]         mx;
      logic [7:0]         mn;
   } vec_t;

   res_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [127:0] l8(input int a0, a1, a2, a3, a4, a5, a6, a7);
      int a[8];
      logic [127:0] r;
      a = '{a0, a1, a2, a3, a4, a5, a6, a7};
      for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(a[i]);
      return r;
   endfunction

   function automatic logic [127:0] rep8(input int v);
      return l8(v, v, v, v, v, v, v, v);
   endfunction

   function automatic logic [63:0] rep4(input int v);
      logic [63:0] r;
      for (int i = 0; i < 4; i++) r[i*16 +: 16] = 16'(v);
      return r;
   endfunction

   // drive one beat on the main instance; returns just after the accepting edge
   task automatic send(input logic md, input logic [1:0] ch, input logic [127:0] d,
                       input logic last);
      int t = 0;
      @(negedge clk);
      mode = md; s_chan = ch; s_data = d; s_last = last; s_valid = 1'b1;
      while (!s_ready && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (!s_ready) begin
         chk("send_ready_timeout", s_ready, 1);
         s_valid = 1'b0;
         s_last  = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         s_valid = 1'b0;
         s_last  = 1'b0;
      end
   endtask

   task automatic send2(input logic [63:0] d, input logic last);
      int t = 0;
      @(negedge clk);
      s_chan2 = 2'd0; s_data2 = d; s_last2 = last; s_valid2 = 1'b1;
      while (!s_ready2 && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (!s_ready2) chk("send2_ready_timeout", s_ready2, 1);
      else begin
         @(posedge clk);
         #1;
      end
      s_valid2 = 1'b0;
      s_last2  = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("scoreboard_drain", exp_q.size(), 0);
   endtask

   task automatic wait_m2(output bit ok);
      int t = 0;
      while (!m_valid2 && t < 300) begin
         @(negedge clk);
         t++;
      end
      ok = m_valid2;
      chk("dut2_result_timeout", m_valid2, 1);
   endtask

   // scoreboard: compare each result as it is handed off
   always @(negedge clk) begin : mon
      res_t r;
      if (rstn && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", m_valid, 0);
         end else begin
            r = exp_q.pop_front();
            chk("m_mean", $signed(m_mean), $signed(r.mean));
            chk("m_var", m_var, r.vr);
            chk("m_count", m_count, r.count);
            chk("m_chan", m_chan, r.chan);
            chk("m_ovf", m_ovf, r.ovf);
         end
      end
   end

   vec_t vecs[11];

   initial begin
      bit ok;
      int n;

      vecs[0]  = '{1'b0, 2'd0, rep8(3), 16'sd3, 32'd0, 8'h01, 8'h01};
      vecs[1]  = '{1'b0, 2'd1, l8(0, 1, 2, 3, 4, 5, 6, 7), 16'sd3, 32'd8, 8'h80, 8'h01};
      vecs[2]  = '{1'b0, 2'd2, rep8(-5), -16'sd5, 32'd0, 8'h01, 8'h01};
      vecs[3]  = '{1'b1, 2'd3, rep8(-5), 16'sd0, 32'd25, 8'h01, 8'h01};
      vecs[4]  = '{1'b0, 2'd0, l8(10, -20, 30, -40, 50, -60, 70, -80), -16'sd5, 32'd2525,
                   8'h40, 8'h80};
      vecs[5]  = '{1'b0, 2'd1, rep8(-32768), 16'sh8000, 32'd0, 8'h01, 8'h01};
      vecs[6]  = '{1'b1, 2'd2, rep8(-32768), 16'sd0, 32'd1073741824, 8'h01, 8'h01};
      vecs[7]  = '{1'b0, 2'd3, l8(-1, 0, 0, 0, 0, 0, 0, 0), 16'sd0, 32'd0, 8'h02, 8'h01};
      vecs[8]  = '{1'b0, 2'd0, l8(-9, 0, 0, 0, 0, 0, 0, 0), -16'sd1, 32'd9, 8'h02, 8'h01};
      vecs[9]  = '{1'b0, 2'd1, l8(5, 7, 7, 1, -3, -3, 2, 0), 16'sd2, 32'd14, 8'h02, 8'h10};
      vecs[10] = '{1'b1, 2'd0, rep8(32767), 16'sd0, 32'd1073676289, 8'h01, 8'h01};

      // reset state
      #12;
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_index_valid", index_valid, 0);
      chk("rst_m_mean", m_mean, 0);
      chk("rst_m_count", m_count, 0);
      chk("rst_m_ovf", m_ovf, 0);
      @(negedge clk);
      rstn = 1'b1;
      #1 chk("rel_s_ready_low", s_ready, 0);
      @(negedge clk);
      chk("rel_s_ready_high", s_ready, 1);

      // single-beat frames: index report, latency, then scoreboard result
      foreach (vecs[i]) begin
         exp_q.push_back('{vecs[i].mean, vecs[i].vr, 15'd8, vecs[i].ch, 1'b0});
         send(vecs[i].md, vecs[i].ch, vecs[i].d, 1'b1);
         n = 0;
         do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
               chk("index_valid", index_valid, 1);
               chk("index_last", index_last, 1);
               chk("max_index", max_index, vecs[i].mx);
               chk("min_index", min_index, vecs[i].mn);
               chk("s_ready_div", s_ready, 0);
            end
            if (n == 2) chk("index_valid_pulse", index_valid, 0);
         end while (!m_valid && n < 200);
         chk("latency", n, QW + 2);
      end
      drain();

      // interleave chan 1 / chan 2, close chan 2 under backpressure
      @(posedge clk);
      #1 m_ready = 1'b0;
      exp_q.push_back('{16'sd15, 32'd25, 15'd16, 2'd2, 1'b0});
      send(1'b0, 2'd1, rep8(2), 1'b0);
      send(1'b0, 2'd2, rep8(10), 1'b0);
      send(1'b0, 2'd1, rep8(4), 1'b0);
      @(negedge clk);
      chk("index_last_mid", index_last, 0);
      send(1'b0, 2'd2, rep8(20), 1'b1);
      n = 0;
      while (!m_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      for (int k = 0; k < 10; k++) begin
         chk("hold_m_valid", m_valid, 1);
         chk("hold_m_mean", $signed(m_mean), 15);
         chk("hold_m_var", m_var, 25);
         chk("hold_m_chan", m_chan, 2);
         chk("hold_s_ready", s_ready, 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 m_ready = 1'b1;
      drain();
      exp_q.push_back('{16'sd4, 32'd2, 15'd24, 2'd1, 1'b0});
      send(1'b0, 2'd1, rep8(6), 1'b1);
      drain();

      // reset in the middle of a division; chan 3 must not keep its stale beat
      send(1'b0, 2'd3, rep8(100), 1'b0);
      send(1'b0, 2'd0, rep8(1), 1'b1);
      repeat (10) @(negedge clk);
      chk("div_m_valid", m_valid, 0);
      #1 rstn = 1'b0;
      #1;
      chk("abort_s_ready", s_ready, 0);
      chk("abort_m_valid", m_valid, 0);
      chk("abort_m_mean", m_mean, 0);
      chk("abort_m_var", m_var, 0);
      chk("abort_m_count", m_count, 0);
      chk("abort_m_chan", m_chan, 0);
      chk("abort_max_index", max_index, 0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      exp_q.push_back('{16'sd7, 32'd0, 15'd8, 2'd3, 1'b0});
      send(1'b0, 2'd3, rep8(7), 1'b1);
      drain();

      // frame-length overflow on the short instance: 5 beats, 3 fit
      for (int b = 0; b < 5; b++) send2(rep4(1), b == 4);
      wait_m2(ok);
      chk("ovf_m_count", m_count2, 12);
      chk("ovf_m_ovf", m_ovf2, 1);
      chk("ovf_m_mean", $signed(m_mean2), 1);
      chk("ovf_m_var", m_var2, 0);
      @(negedge clk);
      send2(rep4(2), 1'b0);
      send2(rep4(2), 1'b1);
      wait_m2(ok);
      chk("next_m_count", m_count2, 8);
      chk("next_m_ovf", m_ovf2, 0);
      chk("next_m_mean", $signed(m_mean2), 2);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
